// File: rtl/generic_pkg.sv
// Shared widths and FSM state type for the register-file spill/fill responder.
package generic_pkg;

  localparam int unsigned NBITS     = 64;
  localparam int unsigned ADDR_SIZE = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPILL_RX,
    ST_FILL_TX
  } spill_state_t;

endpackage

// File: rtl/spill_stack_mem.sv
// Backing store for the spill stack: synchronous write, combinational read.
// The array is intentionally not reset; contents are don't-care after reset.
module spill_stack_mem #(
  parameter int unsigned NBITS = 64,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem_q [DEPTH];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read port: asynchronous, consumed by the top-level output register.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/rf_spill_stack.sv
// Memory-side responder for windowed register-file SPILL/FILL traffic.
// Spilled words are pushed onto a LIFO; a FILL pulse streams one window back
// through a registered output, most recently spilled word first.
module rf_spill_stack
  import generic_pkg::*;
#(
  parameter int unsigned NBITS     = generic_pkg::NBITS,
  parameter int unsigned WIN_WORDS = 16,
  parameter int unsigned DEPTH     = 2 ** ADDR_SIZE,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1,
  localparam int unsigned BW       = $clog2(WIN_WORDS + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             SPILL,
  input  logic [NBITS-1:0] MEM_BUS,
  input  logic             FILL,
  input  logic             CLR_ERR,
  output logic [NBITS-1:0] MEM_BUSread,
  output logic             FILL_VALID,
  output logic             BUSY,
  output logic [CW-1:0]    COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVF_ERR,
  output logic             UNF_ERR,
  output logic             PROTO_ERR
);

  spill_state_t     state_q, state_d;
  logic [CW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    base_q, base_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             proto_q, proto_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;

  logic             do_push, do_pop;
  logic             set_ovf, set_unf, set_proto;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [NBITS-1:0] rdata;

  assign waddr = sp_q[AW-1:0];
  assign raddr = AW'(sp_q - 1'b1);

  spill_stack_mem #(
    .NBITS (NBITS),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (MEM_BUS),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state logic: FSM, stack pointer, burst counter, sticky errors.
  // The first fill word is loaded on the IDLE->FILL_TX edge so it is valid
  // the cycle after FILL; FILL_TX then counts the remaining words and
  // spends its final cycle dropping valid.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    base_d    = base_q;
    bcnt_d    = bcnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    proto_d   = proto_q;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    set_proto = 1'b0;
    we        = 1'b0;

    if (ENABLE) begin
      case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (SPILL) begin
            do_push   = 1'b1;
            base_d    = sp_q;
            bcnt_d    = BW'(1);
            state_d   = (WIN_WORDS == 1) ? ST_IDLE : ST_SPILL_RX;
            set_proto = FILL;
          end else if (FILL) begin
            if (sp_q >= CW'(WIN_WORDS)) begin
              do_pop  = 1'b1;
              bcnt_d  = BW'(1);
              state_d = ST_FILL_TX;
            end else begin
              set_unf = 1'b1;
            end
          end
        end
        ST_SPILL_RX: begin
          if (FILL) set_proto = 1'b1;
          if (SPILL) begin
            do_push = 1'b1;
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == BW'(WIN_WORDS - 1)) state_d = ST_IDLE;
          end else begin
            set_proto = 1'b1;
            sp_d      = base_q;
            state_d   = ST_IDLE;
          end
        end
        ST_FILL_TX: begin
          if (SPILL || FILL) set_proto = 1'b1;
          if (bcnt_q == BW'(WIN_WORDS)) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            do_pop = 1'b1;
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (do_push) begin
        if (sp_q == CW'(DEPTH)) begin
          set_ovf = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end

      if (do_pop) begin
        dout_d  = rdata;
        valid_d = 1'b1;
        sp_d    = sp_q - 1'b1;
      end

      ovf_d   = (ovf_q   & ~CLR_ERR) | set_ovf;
      unf_d   = (unf_q   & ~CLR_ERR) | set_unf;
      proto_d = (proto_q & ~CLR_ERR) | set_proto;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      base_q  <= '0;
      bcnt_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      base_q  <= base_d;
      bcnt_q  <= bcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      proto_q <= proto_d;
    end
  end

  // Output decode; FILL_VALID is masked while the block is frozen.
  always_comb begin
    MEM_BUSread = dout_q;
    FILL_VALID  = valid_q & ENABLE;
    BUSY        = (state_q != ST_IDLE);
    COUNT       = sp_q;
    FULL        = (sp_q == CW'(DEPTH));
    EMPTY       = (sp_q == '0);
    OVF_ERR     = ovf_q;
    UNF_ERR     = unf_q;
    PROTO_ERR   = proto_q;
  end

endmodule

// File: tb/tb_rf_spill_stack.sv
// Randomized scoreboard bench for rf_spill_stack (WIN_WORDS=4, DEPTH=8).
// The reference is a plain queue used as a stack plus three sticky flags.
module tb_rf_spill_stack;

  localparam int unsigned NB  = 64;
  localparam int unsigned WIN = 4;
  localparam int unsigned DEP = 8;

  logic          clk = 1'b0;
  logic          RST, ENABLE, SPILL, FILL, CLR_ERR;
  logic [NB-1:0] MEM_BUS, MEM_BUSread;
  logic          FILL_VALID, BUSY, FULL, EMPTY, OVF_ERR, UNF_ERR, PROTO_ERR;
  logic [3:0]    COUNT;

  rf_spill_stack #(
    .NBITS     (NB),
    .WIN_WORDS (WIN),
    .DEPTH     (DEP)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .SPILL       (SPILL),
    .MEM_BUS     (MEM_BUS),
    .FILL        (FILL),
    .CLR_ERR     (CLR_ERR),
    .MEM_BUSread (MEM_BUSread),
    .FILL_VALID  (FILL_VALID),
    .BUSY        (BUSY),
    .COUNT       (COUNT),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .OVF_ERR     (OVF_ERR),
    .UNF_ERR     (UNF_ERR),
    .PROTO_ERR   (PROTO_ERR)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [NB-1:0] stk[$];
  logic [NB-1:0] exp_q[$];
  bit m_ovf, m_unf, m_proto;
  int unsigned freeze_pct = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented fill word must match the next expected word.
  always @(negedge clk) begin
    if (RST === 1'b1 && FILL_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fill_unexpected: got valid data %0h expected no fill word", MEM_BUSread);
      end else begin
        chk("fill_data", MEM_BUSread, exp_q.pop_front());
      end
    end
  end

  // One enabled cycle, optionally preceded by a frozen cycle with junk inputs.
  task automatic step(input bit sp, input bit fl, input bit cl, input logic [NB-1:0] d,
                      input bit s_ovf, input bit s_unf, input bit s_proto);
    if (freeze_pct != 0 && $urandom_range(99) < freeze_pct) begin
      ENABLE  = 1'b0;
      SPILL   = 1'($urandom_range(1));
      FILL    = 1'($urandom_range(1));
      CLR_ERR = 1'($urandom_range(1));
      MEM_BUS = {$urandom(), $urandom()};
      @(posedge clk); #1;
      chk("frozen_valid", FILL_VALID, 0);
      chk("frozen_errs", {OVF_ERR, UNF_ERR, PROTO_ERR}, {m_ovf, m_unf, m_proto});
    end
    ENABLE  = 1'b1;
    SPILL   = sp;
    FILL    = fl;
    CLR_ERR = cl;
    MEM_BUS = d;
    @(posedge clk); #1;
    if (cl) begin
      m_ovf = 0; m_unf = 0; m_proto = 0;
    end
    m_ovf   |= s_ovf;
    m_unf   |= s_unf;
    m_proto |= s_proto;
    chk("err_flags", {OVF_ERR, UNF_ERR, PROTO_ERR}, {m_ovf, m_unf, m_proto});
    SPILL = 1'b0; FILL = 1'b0; CLR_ERR = 1'b0;
  endtask

  task automatic idle_check();
    chk("count", COUNT, stk.size());
    chk("full", FULL, stk.size() == DEP);
    chk("empty", EMPTY, stk.size() == 0);
    chk("busy_idle", BUSY, 0);
  endtask

  // Spill n words (n<WIN truncates the burst); FILL may be raised on word 0 or 1.
  task automatic spill_burst(input int unsigned n, input bit fill_first, input bit fill_mid);
    int unsigned start = stk.size();
    for (int unsigned i = 0; i < n; i++) begin
      logic [NB-1:0] d = {$urandom(), $urandom()};
      bit fl = (i == 0) ? fill_first : (i == 1 && fill_mid);
      bit full = (stk.size() == DEP);
      if (!full) stk.push_back(d);
      step(1, fl, 0, d, full, 0, fl);
    end
    if (n < WIN) begin
      while (stk.size() > start) void'(stk.pop_back());
      step(0, 0, 0, '0, 0, 0, 1);
    end
    idle_check();
  endtask

  // Request one window; disturb injects SPILL/FILL during the transfer.
  task automatic fill_req(input bit disturb, input bit clr);
    if (stk.size() < WIN) begin
      step(0, 1, clr, '0, 0, 1, 0);
      chk("unf_no_valid", FILL_VALID, 0);
      chk("unf_no_busy", BUSY, 0);
    end else begin
      for (int unsigned i = 0; i < WIN; i++) exp_q.push_back(stk.pop_back());
      step(0, 1, 0, '0, 0, 0, 0);
      chk("fill_first_valid", FILL_VALID, 1);
      chk("fill_busy", BUSY, 1);
      for (int unsigned i = 0; i < WIN; i++) begin
        bit dis = disturb && ($urandom_range(2) == 0);
        bit dsp = dis && ($urandom_range(1) == 1);
        step(dsp, dis && !dsp, 0, {$urandom(), $urandom()}, 0, 0, dis);
      end
      chk("fill_drained", exp_q.size(), 0);
    end
    idle_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; ENABLE = 1'b0; SPILL = 1'b0; FILL = 1'b0; CLR_ERR = 1'b0; MEM_BUS = '0;
    #1;
    chk("rst_outputs", {FILL_VALID, BUSY, COUNT, FULL, EMPTY, OVF_ERR, UNF_ERR, PROTO_ERR},
        {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rst_data", MEM_BUSread, 0);
    @(negedge clk); RST = 1'b1;
    @(posedge clk); #1;

    // Basic spill then fill, LIFO order.
    spill_burst(WIN, 0, 0);
    fill_req(0, 0);
    // Fill to full, then overflow burst, then fill returns second burst.
    spill_burst(WIN, 0, 0);
    spill_burst(WIN, 0, 0);
    chk("full_after_8", FULL, 1);
    spill_burst(WIN, 0, 0);
    chk("ovf_count", COUNT, 8);
    fill_req(0, 0);
    fill_req(0, 0);
    // Underflow, then clear; then underflow with simultaneous clear (set wins).
    fill_req(0, 0);
    step(0, 0, 1, '0, 0, 0, 0);
    fill_req(0, 1);
    step(0, 0, 1, '0, 0, 0, 0);
    // Truncated burst rolls back.
    spill_burst(WIN, 0, 0);
    spill_burst(2, 0, 0);
    chk("trunc_count", COUNT, 4);
    step(0, 0, 1, '0, 0, 0, 0);
    // SPILL and FILL together: spill wins.
    spill_burst(WIN, 1, 0);
    chk("both_count", COUNT, 8);
    step(0, 0, 1, '0, 0, 0, 0);
    // Asynchronous reset in the middle of a fill.
    for (int unsigned i = 0; i < WIN; i++) exp_q.push_back(stk.pop_back());
    step(0, 1, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    #2 RST = 1'b0;
    #1;
    chk("arst_valid", FILL_VALID, 0);
    chk("arst_count", COUNT, 0);
    chk("arst_empty", EMPTY, 1);
    chk("arst_busy", BUSY, 0);
    stk.delete(); exp_q.delete();
    m_ovf = 0; m_unf = 0; m_proto = 0;
    @(posedge clk); #1; RST = 1'b1;
    @(posedge clk); #1;
    idle_check();

    // Randomized traffic with frozen cycles interleaved.
    freeze_pct = 15;
    for (int unsigned it = 0; it < 400; it++) begin
      case ($urandom_range(5))
        0, 1: spill_burst(WIN, $urandom_range(5) == 0, $urandom_range(5) == 0);
        2:    spill_burst($urandom_range(WIN - 1, 1), 0, $urandom_range(3) == 0);
        3, 4: fill_req($urandom_range(1) == 1, 0);
        default: begin
          if ($urandom_range(1) == 1) step(0, 0, 1, '0, 0, 0, 0);
          else fill_req(0, 1);
        end
      endcase
    end
    freeze_pct = 0;
    step(0, 0, 0, '0, 0, 0, 0);
    chk("final_queue", exp_q.size(), 0);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
